// File: rtl/mod_n_counter_if.sv
// Control/status bundle for the modulo-N counter.
interface mod_n_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             mod_we;
    logic [WIDTH-1:0] mod_din;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] last;
    logic             tc;
    logic             wrap;
    logic             err;

    // Controller side: drives requests, observes counter state.
    modport master (
        output en, up_dn, load, din, mod_we, mod_din,
        input  count, last, tc, wrap, err
    );

    // Counter side.
    modport slave (
        input  en, up_dn, load, din, mod_we, mod_din,
        output count, last, tc, wrap, err
    );
endinterface

// File: rtl/mod_n_counter.sv
// Reprogrammable modulo-N up/down counter with checked load, wrap and error pulses,
// and a combinational terminal count for cascading stages.
module mod_n_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 12
) (
    input  logic           clk,
    input  logic           rst,
    mod_n_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] LAST_RST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // Reject moduli outside 2..2**WIDTH at elaboration.
    generate
        if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
            $error("mod_n_counter: MODULUS out of range 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q,  last_d;
    logic             wrap_q,  wrap_d;
    logic             err_q,   err_d;

    logic             mod_ok;
    logic             mod_bad;
    logic [WIDTH-1:0] term;
    logic             load_bad;

    // Decode the modulus write and the terminal value in force this cycle.
    always_comb begin
        mod_ok   = bus.mod_we && (bus.mod_din != ZERO);
        mod_bad  = bus.mod_we && (bus.mod_din == ZERO);
        term     = mod_ok ? bus.mod_din : last_q;
        load_bad = bus.load && (bus.din > term);
    end

    // Next-state: load beats modulus write beats counting.
    always_comb begin
        count_d = count_q;
        last_d  = last_q;
        wrap_d  = 1'b0;
        err_d   = mod_bad | load_bad;

        if (mod_ok) begin
            last_d = bus.mod_din;
        end

        if (bus.load) begin
            count_d = load_bad ? ZERO : bus.din;
        end else if (bus.mod_we) begin
            // A shrinking modulus may leave the count above the new terminal.
            if (mod_ok && (count_q > term)) begin
                count_d = ZERO;
            end
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (count_q == term) begin
                    count_d = ZERO;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == ZERO) begin
                    count_d = term;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= ZERO;
            last_q  <= LAST_RST;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            last_q  <= last_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    // Terminal count is combinational so a downstream stage steps on the same edge.
    always_comb begin
        bus.tc = bus.en & ~bus.load & ~bus.mod_we &
                 (bus.up_dn ? (count_q == last_q) : (count_q == ZERO));
    end

    assign bus.count = count_q;
    assign bus.last  = last_q;
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter: single-stage behaviour plus a two-stage cascade.
module tb_mod_n_counter;

    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_errors;

    mod_n_counter_if #(.WIDTH(4)) lo_if ();
    mod_n_counter_if #(.WIDTH(4)) hi_if ();

    mod_n_counter #(.WIDTH(4), .MODULUS(12)) u_lo (
        .clk (clk),
        .rst (rst),
        .bus (lo_if.slave)
    );

    mod_n_counter #(.WIDTH(4), .MODULUS(12)) u_hi (
        .clk (clk),
        .rst (rst),
        .bus (hi_if.slave)
    );

    // Upper stage steps on the lower stage's terminal count.
    assign hi_if.en      = lo_if.tc;
    assign hi_if.up_dn   = 1'b1;
    assign hi_if.load    = 1'b0;
    assign hi_if.din     = 4'd0;
    assign hi_if.mod_we  = 1'b0;
    assign hi_if.mod_din = 4'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic en, input logic up, input logic ld, input logic [3:0] d,
                          input logic we, input logic [3:0] md);
        lo_if.en      = en;
        lo_if.up_dn   = up;
        lo_if.load    = ld;
        lo_if.din     = d;
        lo_if.mod_we  = we;
        lo_if.mod_din = md;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        set_in(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_count", lo_if.count, 0);
        check("rst_last",  lo_if.last, 11);
        check("rst_wrap",  lo_if.wrap, 0);
        check("rst_err",   lo_if.err, 0);
        check("rst_tc",    lo_if.tc, 0);

        // 1: count up 14 clocks
        set_in(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        check("up_tc0", lo_if.tc, 0);
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("up_count", lo_if.count, i % 12);
            check("up_wrap",  lo_if.wrap, ((i % 12) == 0) ? 1 : 0);
            check("up_tc",    lo_if.tc, ((i % 12) == 11) ? 1 : 0);
        end

        // 2: count down from 0
        set_in(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
        tick();
        check("dn_load0", lo_if.count, 0);
        set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        check("dn_tc0", lo_if.tc, 1);
        tick();
        check("dn_count11", lo_if.count, 11);
        check("dn_wrap",    lo_if.wrap, 1);
        check("dn_tc11",    lo_if.tc, 0);
        tick();
        check("dn_count10", lo_if.count, 10);
        check("dn_wrap10",  lo_if.wrap, 0);
        tick();
        check("dn_count9",  lo_if.count, 9);

        // 3: legal and illegal load (en stays high; load wins)
        set_in(1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 4'd0);
        check("ld_tc_masked", lo_if.tc, 0);
        tick();
        check("ld7_count", lo_if.count, 7);
        check("ld7_err",   lo_if.err, 0);
        check("ld7_wrap",  lo_if.wrap, 0);
        set_in(1'b1, 1'b1, 1'b1, 4'd13, 1'b0, 4'd0);
        tick();
        check("ld13_count", lo_if.count, 0);
        check("ld13_err",   lo_if.err, 1);
        check("ld13_wrap",  lo_if.wrap, 0);
        set_in(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        check("ld13_err_end", lo_if.err, 0);

        // 4: shrink modulus below count, count in new range, illegal write
        set_in(1'b0, 1'b1, 1'b1, 4'd9, 1'b0, 4'd0);
        tick();
        check("m_ld9", lo_if.count, 9);
        set_in(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5);
        tick();
        check("m5_last",  lo_if.last, 5);
        check("m5_count", lo_if.count, 0);
        check("m5_err",   lo_if.err, 0);
        set_in(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("m5_cnt",  lo_if.count, i % 6);
            check("m5_wrap", lo_if.wrap, (i == 6) ? 1 : 0);
        end
        set_in(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0);
        tick();
        check("m0_err",   lo_if.err, 1);
        check("m0_last",  lo_if.last, 5);
        check("m0_count", lo_if.count, 0);
        set_in(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        check("m0_err_end", lo_if.err, 0);

        // 5: simultaneous load and modulus write
        set_in(1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 4'd3);
        tick();
        check("lm_last",  lo_if.last, 3);
        check("lm_count", lo_if.count, 0);
        check("lm_err",   lo_if.err, 1);
        set_in(1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 4'd3);
        tick();
        check("lm2_count", lo_if.count, 2);
        check("lm2_err",   lo_if.err, 0);
        // Both illegal together: single pulse
        set_in(1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 4'd0);
        tick();
        check("both_err",  lo_if.err, 1);
        check("both_last", lo_if.last, 3);
        set_in(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        check("both_err_end", lo_if.err, 0);

        // 6a: async reset mid-cycle during a pending modulus write
        set_in(1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 4'd11);
        tick();
        check("pre_rst_count", lo_if.count, 6);
        check("pre_rst_last",  lo_if.last, 11);
        set_in(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5);
        tick();
        check("pre_rst_last5", lo_if.last, 5);
        check("pre_rst_cnt0",  lo_if.count, 0);
        set_in(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 4'd0);
        tick();
        check("pre_rst_cnt5",  lo_if.count, 5);
        set_in(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd9);
        #1;
        rst = 1'b1;
        #1;
        check("arst_count", lo_if.count, 0);
        check("arst_last",  lo_if.last, 11);
        check("arst_hi",    hi_if.count, 0);
        set_in(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        rst = 1'b0;
        #1;

        // 6b: cascade counts 0..143
        for (int i = 1; i <= 143; i++) begin
            tick();
            check("casc", hi_if.count * 12 + lo_if.count, i);
        end
        check("casc_hi_tc_lo", lo_if.tc, 1);
        tick();
        check("casc_roll_lo", lo_if.count, 0);
        check("casc_roll_hi", hi_if.count, 0);
        check("casc_hi_wrap", hi_if.wrap, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
